// File: rtl/dram_loader_if.sv
// -----------------------------------------------------------------------------
// dram_loader_if
//   Bus bundle for the read-side DMA stage (dram_loader). It carries the
//   state_control handshake, the DRAM read port, the data-memory write port
//   and the status outputs.
//
//   Handshake semantics:
//   - rd_en/rd_done is a level handshake. rd_en is raised to start a transfer.
//     rd_done stays high until rd_en falls.
//   - mem_req/mem_ack is a request/acknowledge pair. mem_req and mem_addr are
//     held stable until mem_ack is seen. A word moves in the cycle where both
//     mem_req and mem_ack are high, and mem_rdata is valid in that cycle only.
//     mem_ack while mem_req is low carries no meaning.
//   - dmem_we is a one-cycle write strobe. There is no back-pressure.
//
//   Modports:
//     master : the loader (drives rd_done, mem_*, dmem_*, busy, checksum)
//     slave  : the environment (drives rd_en, mem_ack, mem_rdata)
//   state_dbg exposes the loader FSM state for observation only.
// -----------------------------------------------------------------------------
interface dram_loader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              rd_en;
    logic              rd_done;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              busy;
    logic [15:0]       checksum;
    logic [1:0]        state_dbg;

    modport master (
        input  rd_en, mem_ack, mem_rdata,
        output rd_done, mem_req, mem_addr, dmem_we, dmem_addr, dmem_wdata,
               busy, checksum, state_dbg
    );

    modport slave (
        output rd_en, mem_ack, mem_rdata,
        input  rd_done, mem_req, mem_addr, dmem_we, dmem_addr, dmem_wdata,
               busy, checksum, state_dbg
    );
endinterface

// File: rtl/dram_loader.sv
// -----------------------------------------------------------------------------
// dram_loader
//   Read-side DMA stage. When rd_en rises it copies IMG_WORDS words from DRAM
//   (starting at DRAM_BASE) into data memory (starting at DMEM_BASE). Only one
//   read request is outstanding at a time. At the end it raises rd_done and
//   holds it until rd_en drops.
//
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous, active-high reset
//     bus   : dram_loader_if.master (rd_en/rd_done, mem_req/mem_addr/mem_ack/
//             mem_rdata, dmem_we/dmem_addr/dmem_wdata, busy, checksum,
//             state_dbg)
//
//   Optional feature (macro DRAM_LOADER_CHECKSUM_EN):
//     When the macro is defined, checksum is a running 16-bit sum of the words
//     written during the current transfer. It is cleared on start and held
//     after completion. When the macro is undefined, checksum is tied to 0.
//
//   Every output is decoded from registered state. Nothing in the output
//   logic depends on the current value of an input.
// -----------------------------------------------------------------------------
module dram_loader #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 8,
    parameter int unsigned       IMG_WORDS = 65536,
    parameter logic [ADDR_W-1:0] DRAM_BASE = '0,
    parameter logic [ADDR_W-1:0] DMEM_BASE = '0
) (
    input  logic          clk,
    input  logic          reset,
    dram_loader_if.master bus
);
    // The counter has one spare bit so that IMG_WORDS = 2^ADDR_W is legal.
    localparam int               CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(IMG_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            data_q <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data_q;
        case (state)
            IDLE: begin
                if (bus.rd_en) begin
                    cnt_nxt   = '0;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // The data is captured only on the ack cycle. Later changes
                // on mem_rdata cannot reach dmem_wdata.
                if (bus.mem_ack) begin
                    data_nxt  = bus.mem_rdata;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                    state_nxt = REQ;
                end
            end
            DONE: begin
                // While rd_en stays high, the loader waits here. It does not
                // restart until rd_en has dropped and risen again.
                if (!bus.rd_en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses wrap modulo 2^ADDR_W. The low ADDR_W counter bits are enough
    // because cnt never exceeds IMG_WORDS-1.
    assign bus.mem_req    = (state == REQ);
    assign bus.mem_addr   = (state == REQ)   ? DRAM_BASE + cnt[ADDR_W-1:0] : '0;
    assign bus.dmem_we    = (state == WRITE);
    assign bus.dmem_addr  = (state == WRITE) ? DMEM_BASE + cnt[ADDR_W-1:0] : '0;
    assign bus.dmem_wdata = (state == WRITE) ? data_q : '0;
    assign bus.busy       = (state == REQ) || (state == WRITE);
    assign bus.rd_done    = (state == DONE);
    assign bus.state_dbg  = state;

`ifdef DRAM_LOADER_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (state == IDLE && bus.rd_en) begin
            sum_q <= '0;
        end else if (state == WRITE) begin
            sum_q <= sum_q + 16'(data_q);
        end
    end

    assign bus.checksum = sum_q;
`else
    assign bus.checksum = 16'h0000;
`endif
endmodule

// File: tb/tb_dram_loader.sv
// -----------------------------------------------------------------------------
// tb_dram_loader
//   Bench for dram_loader. It uses two instances:
//     u_main : IMG_WORDS=4, DRAM_BASE=0, DMEM_BASE=0
//     u_edge : IMG_WORDS=1, DRAM_BASE=0xFFFF, DMEM_BASE=0x00A5
//   A DRAM model answers each instance. The main responder has per-address
//   wait states. While it is not acknowledging, it drives random data on
//   mem_rdata. The expected writes, reads, latency and checksum come from a
//   word-level model of the transfer.
// -----------------------------------------------------------------------------
module tb_dram_loader;
    localparam int          ADDR_W      = 16;
    localparam int          DATA_W      = 8;
    localparam int          W           = ADDR_W + DATA_W;
    localparam int          MAIN_WORDS  = 4;
    localparam logic [15:0] EDGE_DRAM_B = 16'hFFFF;
    localparam logic [15:0] EDGE_DMEM_B = 16'h00A5;
`ifdef DRAM_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dram_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_m ();
    dram_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_e ();

    dram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMG_WORDS(MAIN_WORDS),
                  .DRAM_BASE(16'h0000), .DMEM_BASE(16'h0000))
        u_main (.clk(clk), .reset(reset), .bus(bus_m));

    dram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMG_WORDS(1),
                  .DRAM_BASE(EDGE_DRAM_B), .DMEM_BASE(EDGE_DMEM_B))
        u_edge (.clk(clk), .reset(reset), .bus(bus_e));

    // ---------------- memory model and logs ----------------
    logic [7:0]   dram [0:65535];
    int           wait_tbl [0:MAIN_WORDS-1];
    bit           spur_ack = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [15:0]  exp_rd_q[$];
    logic [W-1:0] got_m_q[$], got_e_q[$];
    logic [15:0]  rd_m_q[$], rd_e_q[$];
    int           req_cycles [0:MAIN_WORDS-1];
    int           addr_glitch;
    logic         prev_req = 1'b0;
    logic [15:0]  prev_addr = '0;

    int tests_run = 0;
    int tests_failed = 0;

    // Main DRAM responder. The address selects the number of wait cycles
    // inserted before mem_ack.
    int wcnt_m = 0;
    int need_m;
    always @(negedge clk) begin
        bus_m.mem_ack   = 1'b0;
        bus_m.mem_rdata = 8'($urandom);
        if (spur_ack) begin
            bus_m.mem_ack   = 1'b1;
            bus_m.mem_rdata = 8'h5A;
        end else if (!reset && bus_m.mem_req) begin
            need_m = (bus_m.mem_addr < 16'(MAIN_WORDS)) ? wait_tbl[bus_m.mem_addr[1:0]] : 0;
            if (wcnt_m >= need_m) begin
                bus_m.mem_ack   = 1'b1;
                bus_m.mem_rdata = dram[bus_m.mem_addr];
                rd_m_q.push_back(bus_m.mem_addr);
                wcnt_m = 0;
            end else begin
                wcnt_m++;
            end
        end else begin
            wcnt_m = 0;
        end
    end

    // Edge DRAM responder: always acknowledges with zero wait.
    always @(negedge clk) begin
        bus_e.mem_ack   = 1'b0;
        bus_e.mem_rdata = 8'($urandom);
        if (!reset && bus_e.mem_req) begin
            bus_e.mem_ack   = 1'b1;
            bus_e.mem_rdata = dram[bus_e.mem_addr];
            rd_e_q.push_back(bus_e.mem_addr);
        end
    end

    // Monitors: record data-memory writes and request activity.
    always @(negedge clk) begin
        if (bus_m.dmem_we) got_m_q.push_back({bus_m.dmem_addr, bus_m.dmem_wdata});
        if (bus_e.dmem_we) got_e_q.push_back({bus_e.dmem_addr, bus_e.dmem_wdata});
        if (bus_m.mem_req && bus_m.mem_addr < 16'(MAIN_WORDS))
            req_cycles[bus_m.mem_addr[1:0]]++;
        if (prev_req && bus_m.mem_req && bus_m.mem_addr != prev_addr) addr_glitch++;
        prev_req  = bus_m.mem_req;
        prev_addr = bus_m.mem_addr;
    end

    // ---------------- reference model ----------------
    // A transfer of n words writes dram[sbase+i] to dbase+i, in order, and
    // reads sbase+i. Both addresses wrap at 16 bits. Returns the 16-bit sum.
    function automatic logic [15:0] model_transfer(input logic [15:0] sbase,
                                                   input logic [15:0] dbase,
                                                   input int n);
        logic [15:0] s;
        s = 16'h0;
        exp_q.delete();
        exp_rd_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_rd_q.push_back(sbase + 16'(i));
            exp_q.push_back({dbase + 16'(i), dram[sbase + 16'(i)]});
            s = s + 16'(dram[sbase + 16'(i)]);
        end
        return s & {16{CK_EN}};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        got_m_q.delete(); got_e_q.delete();
        rd_m_q.delete();  rd_e_q.delete();
        for (int i = 0; i < MAIN_WORDS; i++) req_cycles[i] = 0;
        addr_glitch = 0;
    endtask

    task automatic start_main();
        @(negedge clk);
        bus_m.rd_en = 1'b1;
    endtask

    // Counts rising edges from the one that samples rd_en=1 up to the one
    // after which rd_done is seen. If pulse is set, rd_en is dropped right
    // after the sample edge.
    task automatic wait_done(input bit pulse, output int edges, output int busy_bad);
        edges = 0;
        busy_bad = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (pulse) bus_m.rd_en = 1'b0;
            if (!bus_m.rd_done && !bus_m.busy) busy_bad++;
        end while (!bus_m.rd_done && edges < 300);
    endtask

    task automatic release_main();
        @(negedge clk);
        bus_m.rd_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus_m.rd_en = 1'b0;
        bus_e.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({bus_m.rd_done, bus_m.mem_req, bus_m.mem_addr, bus_m.dmem_we, bus_m.dmem_addr,
             bus_m.dmem_wdata, bus_m.busy, bus_m.checksum} !== 60'h0) begin
            tests_failed++;
            $display("FAIL reset_main got rd_done=%b req=%b addr=%h we=%b daddr=%h wdata=%h busy=%b ck=%h exp all 0",
                     bus_m.rd_done, bus_m.mem_req, bus_m.mem_addr, bus_m.dmem_we, bus_m.dmem_addr,
                     bus_m.dmem_wdata, bus_m.busy, bus_m.checksum);
        end
        tests_run++;
        if ({bus_e.rd_done, bus_e.mem_req, bus_e.mem_addr, bus_e.dmem_we, bus_e.dmem_addr,
             bus_e.dmem_wdata, bus_e.busy, bus_e.checksum} !== 60'h0) begin
            tests_failed++;
            $display("FAIL reset_edge got req=%b addr=%h we=%b daddr=%h exp all 0",
                     bus_e.mem_req, bus_e.mem_addr, bus_e.dmem_we, bus_e.dmem_addr);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int edges, busy_bad;
        logic [15:0] ck;
        dram[0] = 8'h11; dram[1] = 8'h22; dram[2] = 8'h33; dram[3] = 8'h44;
        for (int i = 0; i < MAIN_WORDS; i++) wait_tbl[i] = 0;
        ck = model_transfer(16'h0000, 16'h0000, MAIN_WORDS);
        clear_logs();
        start_main();
        wait_done(1'b0, edges, busy_bad);
        tests_run++;
        if (edges !== 2 * MAIN_WORDS + 1) begin
            tests_failed++; $display("FAIL basic_latency got %0d exp %0d", edges, 2 * MAIN_WORDS + 1);
        end
        tests_run++;
        if (busy_bad !== 0) begin
            tests_failed++; $display("FAIL basic_busy got %0d low cycles exp 0", busy_bad);
        end
        tests_run++;
        if (bus_m.busy !== 1'b0) begin
            tests_failed++; $display("FAIL basic_busy_done got %b exp 0", bus_m.busy);
        end
        tests_run++;
        if (got_m_q.size() != exp_q.size()) begin
            tests_failed++; $display("FAIL basic_wr_count got %0d exp %0d", got_m_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                tests_run++;
                if (got_m_q[i] !== exp_q[i]) begin
                    tests_failed++; $display("FAIL basic_wr[%0d] got %h exp %h", i, got_m_q[i], exp_q[i]);
                end
            end
        end
        tests_run++;
        if (rd_m_q != exp_rd_q) begin
            tests_failed++; $display("FAIL basic_reads got %0d reads first %h exp %0d from %h",
                                     rd_m_q.size(), (rd_m_q.size() > 0) ? rd_m_q[0] : 16'hxxxx,
                                     exp_rd_q.size(), exp_rd_q[0]);
        end
        tests_run++;
        if (bus_m.checksum !== ck) begin
            tests_failed++; $display("FAIL basic_checksum got %h exp %h", bus_m.checksum, ck);
        end
        release_main();
    endtask

    task automatic test_wait_states();
        int edges, busy_bad;
        for (int i = 0; i < MAIN_WORDS; i++) wait_tbl[i] = 0;
        wait_tbl[2] = 3;
        void'(model_transfer(16'h0000, 16'h0000, MAIN_WORDS));
        clear_logs();
        start_main();
        wait_done(1'b0, edges, busy_bad);
        tests_run++;
        if (edges !== 2 * MAIN_WORDS + 1 + 3) begin
            tests_failed++; $display("FAIL wait_latency got %0d exp %0d", edges, 2 * MAIN_WORDS + 4);
        end
        tests_run++;
        if (req_cycles[2] !== 4 || req_cycles[1] !== 1) begin
            tests_failed++; $display("FAIL wait_req_hold got addr2=%0d addr1=%0d exp 4 and 1",
                                     req_cycles[2], req_cycles[1]);
        end
        tests_run++;
        if (addr_glitch !== 0) begin
            tests_failed++; $display("FAIL wait_addr_stable got %0d changes exp 0", addr_glitch);
        end
        tests_run++;
        if (got_m_q != exp_q) begin
            tests_failed++; $display("FAIL wait_writes got %0d writes exp %0d (or contents differ)",
                                     got_m_q.size(), exp_q.size());
        end
        wait_tbl[2] = 0;
        release_main();
    endtask

    task automatic test_handshake();
        int edges, busy_bad, held;
        logic [15:0] ck;
        ck = model_transfer(16'h0000, 16'h0000, MAIN_WORDS);
        clear_logs();
        start_main();
        wait_done(1'b0, edges, busy_bad);
        held = 0;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            if (bus_m.rd_done && !bus_m.mem_req) held++;
        end
        tests_run++;
        if (held !== 5 || got_m_q.size() !== MAIN_WORDS || rd_m_q.size() !== MAIN_WORDS) begin
            tests_failed++; $display("FAIL hs_hold got held=%0d writes=%0d reads=%0d exp 5 %0d %0d",
                                     held, got_m_q.size(), rd_m_q.size(), MAIN_WORDS, MAIN_WORDS);
        end
        bus_m.rd_en = 1'b0;
        @(posedge clk); @(negedge clk);
        tests_run++;
        if (bus_m.rd_done !== 1'b0) begin
            tests_failed++; $display("FAIL hs_release got rd_done=%b exp 0", bus_m.rd_done);
        end
        tests_run++;
        if (bus_m.checksum !== ck) begin
            tests_failed++; $display("FAIL hs_ck_held got %h exp %h", bus_m.checksum, ck);
        end
        // A one-cycle pulse on rd_en must still run a complete transfer from address 0.
        clear_logs();
        start_main();
        wait_done(1'b1, edges, busy_bad);
        tests_run++;
        if (edges !== 2 * MAIN_WORDS + 1 || rd_m_q != exp_rd_q || got_m_q != exp_q) begin
            tests_failed++; $display("FAIL hs_pulse got edges=%0d first_rd=%h writes=%0d exp %0d 0000 %0d",
                                     edges, (rd_m_q.size() > 0) ? rd_m_q[0] : 16'hxxxx,
                                     got_m_q.size(), 2 * MAIN_WORDS + 1, MAIN_WORDS);
        end
        @(posedge clk); @(negedge clk);
        tests_run++;
        if (bus_m.rd_done !== 1'b0) begin
            tests_failed++; $display("FAIL hs_pulse_exit got rd_done=%b exp 0", bus_m.rd_done);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int edges, busy_bad;
        bit found;
        for (int i = 0; i < MAIN_WORDS; i++) wait_tbl[i] = 0;
        wait_tbl[2] = 10;
        void'(model_transfer(16'h0000, 16'h0000, MAIN_WORDS));
        clear_logs();
        start_main();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus_m.mem_req && bus_m.mem_addr == 16'd2) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++; $display("FAIL rstmid_reach got no REQ at addr 2 exp REQ at addr 2");
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({bus_m.mem_req, bus_m.dmem_we, bus_m.busy, bus_m.rd_done} !== 4'b0000) begin
            tests_failed++; $display("FAIL rstmid_async got req=%b we=%b busy=%b done=%b exp 0000",
                                     bus_m.mem_req, bus_m.dmem_we, bus_m.busy, bus_m.rd_done);
        end
        wait_tbl[2] = 0;
        @(negedge clk);
        clear_logs();
        @(negedge clk);
        reset = 1'b0;
        wait_done(1'b0, edges, busy_bad);
        tests_run++;
        if (edges !== 2 * MAIN_WORDS + 1 || rd_m_q != exp_rd_q || got_m_q != exp_q) begin
            tests_failed++; $display("FAIL rstmid_restart got edges=%0d first_rd=%h writes=%0d exp %0d 0000 %0d",
                                     edges, (rd_m_q.size() > 0) ? rd_m_q[0] : 16'hxxxx,
                                     got_m_q.size(), 2 * MAIN_WORDS + 1, MAIN_WORDS);
        end
        release_main();
    endtask

    task automatic test_boundary();
        int edges;
        logic [15:0] ck;
        // A spurious ack in IDLE must be ignored.
        clear_logs();
        @(posedge clk); #1 spur_ack = 1'b1;
        @(posedge clk); #1 spur_ack = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (got_m_q.size() !== 0 || bus_m.busy !== 1'b0 || bus_m.rd_done !== 1'b0) begin
            tests_failed++; $display("FAIL spurious_ack got writes=%0d busy=%b done=%b exp 0 0 0",
                                     got_m_q.size(), bus_m.busy, bus_m.rd_done);
        end
        // Single-word transfer at the top of the DRAM address space.
        dram[16'hFFFF] = 8'($urandom_range(1, 255));
        ck = model_transfer(EDGE_DRAM_B, EDGE_DMEM_B, 1);
        clear_logs();
        @(negedge clk);
        bus_e.rd_en = 1'b1;
        edges = 0;
        do begin
            @(posedge clk); edges++;
            @(negedge clk);
        end while (!bus_e.rd_done && edges < 50);
        tests_run++;
        if (edges !== 3) begin
            tests_failed++; $display("FAIL edge_latency got %0d exp 3", edges);
        end
        tests_run++;
        if (rd_e_q != exp_rd_q || got_e_q != exp_q) begin
            tests_failed++; $display("FAIL edge_transfer got rd=%h wr=%h exp rd=%h wr=%h",
                                     (rd_e_q.size() > 0) ? rd_e_q[0] : 16'hxxxx,
                                     (got_e_q.size() > 0) ? got_e_q[0] : {W{1'bx}},
                                     exp_rd_q[0], exp_q[0]);
        end
        tests_run++;
        if (bus_e.checksum !== ck) begin
            tests_failed++; $display("FAIL edge_checksum got %h exp %h", bus_e.checksum, ck);
        end
        @(negedge clk);
        bus_e.rd_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_checksum();
        int edges, busy_bad;
        logic [15:0] exp_ck;
        for (int i = 0; i < MAIN_WORDS; i++) begin
            dram[i] = 8'hFF;
            wait_tbl[i] = 0;
        end
        exp_ck = CK_EN ? 16'h03FC : 16'h0000;
        clear_logs();
        start_main();
        wait_done(1'b0, edges, busy_bad);
        tests_run++;
        if (bus_m.checksum !== exp_ck) begin
            tests_failed++; $display("FAIL checksum_ff got %h exp %h", bus_m.checksum, exp_ck);
        end
        release_main();
        tests_run++;
        if (bus_m.checksum !== exp_ck) begin
            tests_failed++; $display("FAIL checksum_idle got %h exp %h", bus_m.checksum, exp_ck);
        end
    endtask

    task automatic test_random();
        int edges, busy_bad, wsum;
        bit pulse;
        logic [15:0] ck;
        for (int it = 0; it < 6; it++) begin
            wsum = 0;
            for (int i = 0; i < MAIN_WORDS; i++) begin
                dram[i] = 8'($urandom);
                wait_tbl[i] = $urandom_range(0, 3);
                wsum += wait_tbl[i];
            end
            pulse = 1'($urandom_range(0, 1));
            ck = model_transfer(16'h0000, 16'h0000, MAIN_WORDS);
            clear_logs();
            start_main();
            wait_done(pulse, edges, busy_bad);
            tests_run++;
            if (edges !== 2 * MAIN_WORDS + 1 + wsum || busy_bad !== 0 || addr_glitch !== 0) begin
                tests_failed++; $display("FAIL rand%0d_timing got edges=%0d busy_low=%0d glitch=%0d exp %0d 0 0",
                                         it, edges, busy_bad, addr_glitch, 2 * MAIN_WORDS + 1 + wsum);
            end
            tests_run++;
            if (got_m_q != exp_q || rd_m_q != exp_rd_q) begin
                tests_failed++; $display("FAIL rand%0d_data got writes=%0d reads=%0d exp %0d %0d (or contents differ)",
                                         it, got_m_q.size(), rd_m_q.size(), exp_q.size(), exp_rd_q.size());
            end
            tests_run++;
            if (bus_m.checksum !== ck) begin
                tests_failed++; $display("FAIL rand%0d_checksum got %h exp %h", it, bus_m.checksum, ck);
            end
            release_main();
        end
    endtask

    initial begin
        for (int i = 0; i < MAIN_WORDS; i++) wait_tbl[i] = 0;
        test_reset();
        test_basic();
        test_wait_states();
        test_handshake();
        test_reset_mid();
        test_boundary();
        test_checksum();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
